// File: rtl/audio_in_i2s_rx.sv
// audio_in_i2s_rx: deserializes codec ADC I2S data (codec is bit-clock and
// LR-clock master) into stereo frames, buffers them in a FIFO and exposes
// the FIFO plus a control/status register through an Avalon-MM slave.
module audio_in_i2s_rx #(
    parameter int DEPTH       = 16,
    parameter int SAMPLE_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aud_bclk,
    input  logic        aud_adclrck,
    input  logic        aud_adcdat,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam int FW = 2 * SAMPLE_BITS;

    logic                   bclk_s1, bclk_s2, bclk_prev;
    logic                   lrck_s1, lrck_s2;
    logic                   dat_s1, dat_s2;
    logic                   bclk_rise;

    logic [CW-1:0]          bitcnt;
    logic                   lrck_q;
    logic [SAMPLE_BITS-2:0] shreg;
    logic [SAMPLE_BITS-1:0] shift_next;
    logic                   word_done;
    logic [SAMPLE_BITS-1:0] left_hold, right_hold;
    logic                   left_valid;
    logic                   push_req;

    logic [FW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   enable, overflow;
    logic                   empty, full;
    logic                   pop, ctrl_wr, flush, push_try, do_push;
    logic                   unused_bits;

    // All three codec lines take the same two-stage path so they stay aligned;
    // they carry no state worth resetting, so they are left free-running.
    always_ff @(posedge clk) begin
        bclk_s1   <= aud_bclk;
        bclk_s2   <= bclk_s1;
        bclk_prev <= bclk_s2;
        lrck_s1   <= aud_adclrck;
        lrck_s2   <= lrck_s1;
        dat_s1    <= aud_adcdat;
        dat_s2    <= dat_s1;
    end

    assign bclk_rise  = bclk_s2 & ~bclk_prev;
    // shreg only holds the bits received so far; the word is complete when the
    // incoming bit is appended to it.
    assign shift_next = {shreg, dat_s2};
    assign word_done  = (bitcnt == CW'(SAMPLE_BITS - 1));

    // Bit capture: LRCK change marks the I2S delay slot, then MSB-first bits;
    // a right word is only turned into a frame if a left word precedes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt     <= '0;
            lrck_q     <= 1'b0;
            shreg      <= '0;
            left_hold  <= '0;
            right_hold <= '0;
            left_valid <= 1'b0;
            push_req   <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (bclk_rise) begin
                if (lrck_s2 != lrck_q) begin
                    bitcnt <= '0;
                    lrck_q <= lrck_s2;
                    shreg  <= '0;
                end else if (bitcnt < CW'(SAMPLE_BITS)) begin
                    shreg  <= shift_next[SAMPLE_BITS-2:0];
                    bitcnt <= bitcnt + 1'b1;
                    if (word_done) begin
                        if (!lrck_q) begin
                            left_hold  <= shift_next;
                            left_valid <= 1'b1;
                        end else if (left_valid) begin
                            right_hold <= shift_next;
                            push_req   <= 1'b1;
                            left_valid <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign pop      = chipselect & read & ~address & ~empty;
    assign ctrl_wr  = chipselect & write & address;
    assign flush    = ctrl_wr & writedata[2];
    assign push_try = push_req & enable;
    assign do_push  = push_try & ~full;

    // Frame storage; the array is not reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= {left_hold, right_hold};
        end
    end

    // FIFO pointers and occupancy; a flush overrides any push or pop that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (!do_push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Control bits; a dropped frame in the same cycle as a clear keeps overflow set
    // so the loss is never hidden from software.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= writedata[0];
            end
            if (push_try && full) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && writedata[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Zero-latency read mux: FIFO head on DATA, packed status on CTRL/STATUS.
    always_comb begin
        readdata = '0;
        if (chipselect && read) begin
            if (!address) begin
                if (!empty) begin
                    readdata = 32'(mem[rd_ptr]);
                end
            end else begin
                readdata[0]      = enable;
                readdata[1]      = overflow;
                readdata[2]      = empty;
                readdata[8+AW:8] = count;
            end
        end
    end

    assign irq = enable & ~empty;

    assign unused_bits = &{1'b0, writedata[31:3]};

endmodule

// File: tb/tb_audio_in_i2s_rx.sv
// tb_audio_in_i2s_rx: directed bench for the I2S capture FIFO. Drives I2S
// frames at BCLK = clk/16 and checks status, data order, latency, overflow,
// same-cycle push/pop, flush and mid-word reset behaviour.
module tb_audio_in_i2s_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        aud_bclk, aud_adclrck, aud_adcdat;
    logic        chipselect, read, write, address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int testCount = 0;
    int failCount = 0;

    audio_in_i2s_rx #(.DEPTH(16), .SAMPLE_BITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends with a report
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clock edges and settle 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One BCLK period: data/LRCK change with the falling edge, 8 clk low,
    // then rise; optionally return right at the rise so the caller can watch
    // the latency edge by edge.
    task automatic applyStimulus(input logic lr, input logic d, input bit stopAtRise);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        tick(8);
        aud_bclk = 1'b1;
        if (!stopAtRise) tick(8);
    endtask

    // Delay slot followed by 16 bits, MSB first
    task automatic sendWord(input logic lr, input logic [15:0] w, input bit stopAtRise);
        applyStimulus(lr, 1'b0, 1'b0);
        for (int i = 15; i > 0; i--) applyStimulus(lr, w[i], 1'b0);
        applyStimulus(lr, w[0], stopAtRise);
    endtask

    task automatic sendFrame(input logic [15:0] l, input logic [15:0] r, input bit stopAtRise);
        sendWord(1'b0, l, 1'b0);
        sendWord(1'b1, r, stopAtRise);
    endtask

    // Status read without consuming a clock edge
    task automatic peekStatus(output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    // DATA read: sample the combinational value, then let the edge pop
    task automatic busRead(output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 1'b0;
        #1;
        d = readdata;
        tick(1);
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic busWrite(input logic a, input logic [31:0] wd);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = wd;
        tick(1);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    initial begin
        logic [31:0] d;

        reset       = 1'b1;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b0;
        aud_adcdat  = 1'b0;
        chipselect  = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        address     = 1'b0;
        writedata   = '0;
        tick(3);
        checkOutput("reset_readdata", readdata, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick(1);
        peekStatus(d);
        checkOutput("status_after_reset", d, 32'h0000_0004);
        busWrite(1'b1, 32'h1);
        peekStatus(d);
        checkOutput("status_enabled", d, 32'h0000_0005);

        // Stream starts mid-right-word: delay slot plus 5 stray right bits
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        sendFrame(16'hA5C3, 16'h1234, 1'b1);
        tick(1);
        checkOutput("lat_edge1_irq", {31'b0, irq}, 32'h0);
        tick(2);
        peekStatus(d);
        checkOutput("lat_edge3_status", d, 32'h0000_0005);
        tick(1);
        checkOutput("lat_edge4_irq", {31'b0, irq}, 32'h1);
        peekStatus(d);
        checkOutput("lat_edge4_status", d, 32'h0000_0101);
        tick(4);
        busRead(d);
        checkOutput("first_frame_data", d, 32'hA5C3_1234);
        peekStatus(d);
        checkOutput("after_pop_status", d, 32'h0000_0005);
        checkOutput("after_pop_irq", {31'b0, irq}, 32'h0);

        // 17 frames into a 16-deep FIFO with no reads
        for (int i = 1; i <= 17; i++) sendFrame(16'(16'h1000 + i), 16'(16'h2000 + i), 1'b0);
        peekStatus(d);
        checkOutput("ovf_status", d, 32'h0000_1003);
        checkOutput("ovf_irq", {31'b0, irq}, 32'h1);
        for (int i = 1; i <= 16; i++) begin
            busRead(d);
            checkOutput("ovf_read_order", d, {16'(16'h1000 + i), 16'(16'h2000 + i)});
        end
        busRead(d);
        checkOutput("ovf_read_empty", d, 32'h0);
        peekStatus(d);
        checkOutput("ovf_drained_status", d, 32'h0000_0007);
        busWrite(1'b1, 32'h3);
        peekStatus(d);
        checkOutput("ovf_cleared_status", d, 32'h0000_0005);

        // Pop coinciding with the push of frame 6 at count 5
        for (int i = 1; i <= 5; i++) sendFrame(16'(16'h3000 + i), 16'(16'h4000 + i), 1'b0);
        peekStatus(d);
        checkOutput("cnt5_status", d, 32'h0000_0501);
        sendFrame(16'h3006, 16'h4006, 1'b1);
        tick(3);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 1'b0;
        #1;
        checkOutput("cnt5_pop_data", readdata, 32'h3001_4001);
        tick(1);
        chipselect = 1'b0;
        read       = 1'b0;
        tick(4);
        peekStatus(d);
        checkOutput("cnt5_after_status", d, 32'h0000_0501);
        for (int i = 2; i <= 6; i++) begin
            busRead(d);
            checkOutput("cnt5_read_order", d, {16'(16'h3000 + i), 16'(16'h4000 + i)});
        end
        peekStatus(d);
        checkOutput("cnt5_drained_status", d, 32'h0000_0005);

        // Pop coinciding with a push at count 16: the pushed frame is dropped
        for (int i = 1; i <= 16; i++) sendFrame(16'(16'h5000 + i), 16'(16'h6000 + i), 1'b0);
        peekStatus(d);
        checkOutput("cnt16_status", d, 32'h0000_1001);
        sendFrame(16'h5011, 16'h6011, 1'b1);
        tick(3);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 1'b0;
        #1;
        checkOutput("cnt16_pop_data", readdata, 32'h5001_6001);
        tick(1);
        chipselect = 1'b0;
        read       = 1'b0;
        tick(4);
        peekStatus(d);
        checkOutput("cnt16_after_status", d, 32'h0000_0F03);
        busRead(d);
        checkOutput("cnt16_next_data", d, 32'h5002_6002);
        busWrite(1'b1, 32'h7);
        peekStatus(d);
        checkOutput("flush_clear_status", d, 32'h0000_0005);

        // Enable+flush write landing on the push edge
        sendFrame(16'h7001, 16'h8001, 1'b0);
        peekStatus(d);
        checkOutput("pre_flush_status", d, 32'h0000_0101);
        sendFrame(16'h7002, 16'h8002, 1'b1);
        tick(3);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 1'b1;
        writedata  = 32'h5;
        tick(1);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        tick(4);
        peekStatus(d);
        checkOutput("flush_push_status", d, 32'h0000_0005);
        checkOutput("flush_push_irq", {31'b0, irq}, 32'h0);

        // Reset for one clk in the middle of a left word
        sendFrame(16'h9001, 16'hA001, 1'b0);
        checkOutput("pre_reset_irq", {31'b0, irq}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 1'b0;
        reset      = 1'b1;
        tick(1);
        checkOutput("in_reset_readdata", readdata, 32'h0);
        checkOutput("in_reset_irq", {31'b0, irq}, 32'h0);
        reset      = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        peekStatus(d);
        checkOutput("post_reset_status", d, 32'h0000_0004);
        busWrite(1'b1, 32'h1);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        sendWord(1'b1, 16'hBEEF, 1'b0);
        peekStatus(d);
        checkOutput("post_reset_no_push", d, 32'h0000_0005);
        sendFrame(16'h1357, 16'h2468, 1'b0);
        peekStatus(d);
        checkOutput("post_reset_push_status", d, 32'h0000_0101);
        busRead(d);
        checkOutput("post_reset_data", d, 32'h1357_2468);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/audio_in_i2s_rx.md
# audio_in_i2s_rx

Capture-side counterpart of the audio output path. The block deserializes WM8731 ADC I2S data (codec is BCLK/ADCLRCK master) into 16-bit left/right sample pairs and buffers them in a FIFO. The HPS driver drains the FIFO through an Avalon-MM slave inside `soc_system`. `irq` signals available data.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in stereo frames. Must be a power of two, ≥ 2.
- `SAMPLE_BITS`, 16: bits captured per channel, MSB first.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain). Must be ≥ 4× BCLK.
- `reset`  in  1  synchronous, active-high.
- `aud_bclk`  in  1  codec bit clock, asynchronous.
- `aud_adclrck`  in  1  codec ADC LR clock, asynchronous. 0 = left, 1 = right.
- `aud_adcdat`  in  1  codec ADC serial data, asynchronous.
- `chipselect`  in  1  Avalon-MM select.
- `read`  in  1  Avalon-MM read strobe.
- `write`  in  1  Avalon-MM write strobe.
- `address`  in  1  0 = DATA, 1 = CTRL/STATUS.
- `writedata`  in  32  Avalon-MM write data.
- `readdata`  out  32  Avalon-MM read data. Combinational, read latency 0.
- `irq`  out  1  high when `enable` is set and the FIFO is non-empty.

## Operation
- Synchronization: BCLK, ADCLRCK and ADCDAT each pass through a 2-FF synchronizer, so all three see equal delay.
  - A third register holds the previous synced BCLK.
  - `bclk_rise` = synced BCLK & ~previous, one clk wide.
- Bit capture: all capture actions below happen only in a `bclk_rise` cycle.
  - If synced LRCK ≠ `lrck_q` (the LRCK value from the previous rise): this is the I2S delay slot. The data bit is ignored, `bitcnt` is set to 0, `lrck_q` is updated, and the shift register is cleared.
  - Otherwise, if `bitcnt` < `SAMPLE_BITS`: the data bit shifts in at the LSB (MSB arrives first) and `bitcnt` increments.
  - Bits beyond `SAMPLE_BITS` are ignored until the next LRCK change.
  - When `bitcnt` reaches `SAMPLE_BITS` on a left word: `left_hold` is loaded and `left_valid` is set.
  - When `bitcnt` reaches `SAMPLE_BITS` on a right word with `left_valid` set: `push_req` is set for the next clk and `left_valid` is cleared.
  - A right word completed with `left_valid` clear is discarded. This guarantees that frames start with left.
- FIFO: each entry is {left[15:0], right[15:0]}. A push occurs in the cycle after `push_req`, only when `enable` = 1.
  - Full at push time, evaluated on the pre-pop count: the frame is dropped and sticky `overflow` is set.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
- DATA read (address 0, chipselect & read):
  - Non-empty: `readdata` = head entry and the FIFO pops at the clock edge.
  - Empty: `readdata` = 0 and nothing pops.
- STATUS read (address 1), fields of `readdata`:
  - bit0 = `enable`
  - bit1 = `overflow`
  - bit2 = empty
  - bits[8+log2(DEPTH):8] = count
  - all other bits 0
- CTRL write (address 1):
  - bit0 → `enable`.
  - bit1 = 1 clears `overflow`.
  - bit2 = 1 flushes the FIFO (count = 0). Flush wins over a same-cycle push or pop.
  - Clearing `enable` stops pushes but does not flush, and capture continues running.
- A write to address 0 is ignored.

## Timing
- Reset values:
  - `readdata` = 0 (no read active), `irq` = 0.
  - `enable` = 0, `overflow` = 0, FIFO empty.
  - `bitcnt` = 0, `left_valid` = 0, `lrck_q` = 0, `push_req` = 0.
- Reset asserted mid-word or mid-frame discards the partial sample and any held left sample. The first frame after reset requires a fresh left word.
- Latency: 4 clk edges from the edge that first samples the final right-channel BCLK rise high until the FIFO count increments and `irq` rises:
  - edge 1: sync FF1
  - edge 2: sync FF2, so `bclk_rise` is high in the following cycle
  - edge 3: shift and `push_req` set
  - edge 4: FIFO write
- `irq` is driven combinationally from registered state and falls in the cycle after the pop that empties the FIFO.
- Sustained throughput: one frame per LRCK period. The FIFO read side accepts one pop per clk.

## Test plan
- Reset, enable=1, send I2S frames L=0xA5C3, R=0x1234 at BCLK = clk/16 → count=1, `irq`=1 four clk edges after the last right BCLK rise. DATA read returns 0xA5C31234, then count=0 and `irq`=0.
- Start the stream mid-right-word after enable → the partial right word is discarded. First DATA read returns the first complete left/right pair.
- Push 17 frames with DEPTH=16 and no reads → count=16, `overflow`=1. Reads return frames 1–16 in order; a 17th read returns 0 with empty=1. Write CTRL bit1 → `overflow`=0.
- Pop the head in the same cycle that `push_req` fires at count=5 → count stays 5 and data order is preserved. Repeat at count=16: the frame is dropped and `overflow` is set.
- CTRL write 0x5 (enable plus flush) coinciding with a push → count=0, the pushed frame is lost, `enable`=1.
- Assert reset for 1 clk mid-left-word, then continue the stream → no push until a full left word followed by a full right word arrives. All outputs are 0 during reset.
